// File: rtl/spram_access_ctrl.sv
// ---------------------------------------------------------------------------
// spram_access_ctrl
//   Requester-side controller for a single-port RAM with a fixed read latency.
//   Requests arrive on a valid/ready channel and drive the RAM pins in the
//   same cycle. Reads are tracked through the RAM pipeline and their data is
//   captured in a small response FIFO. Read data is returned in request order
//   on a valid/ready response channel. A credit count that covers both the
//   reads still inside the RAM and the FIFO occupancy makes sure every issued
//   read already owns a FIFO slot, so response backpressure never drops data.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake; req_we selects write (1) or read
//   req_addr, req_wdata   request word address and write data
//   rsp_valid/rsp_ready   response handshake; rsp_data is the read word
//   ram_rst               RAM reset, the inverse of rst_n
//   ram_en, ram_we        RAM enable and write enable
//   ram_addr, ram_din     RAM address and write data
//   ram_dout              RAM read data, valid LATENCY cycles after a read
// ---------------------------------------------------------------------------
module spram_access_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 128,
   parameter int LATENCY    = 1,
   parameter int FIFO_DEPTH = LATENCY + 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [$clog2(DEPTH)-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_data,
   output logic                     ram_rst,
   output logic                     ram_en,
   output logic                     ram_we,
   output logic [$clog2(DEPTH)-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_din,
   input  logic [DATA_WIDTH-1:0]    ram_dout
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic                  w_accept;
   logic                  w_rdAccept;
   logic                  w_push;
   logic                  w_pop;
   logic [LATENCY-1:0]    r_inflight;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wrPtr;
   logic [PW-1:0]         r_rdPtr;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         r_outstanding;

   // Pointers wrap explicitly so the FIFO depth does not have to be a power
   // of two.
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // The request side sees only registered credit state, so there is no
   // combinational path from rsp_ready to req_ready. Writes never consume a
   // credit and therefore never stall.
   assign req_ready  = rst_n & (req_we | (r_outstanding < CW'(FIFO_DEPTH)));
   assign w_accept   = req_valid & req_ready;
   assign w_rdAccept = w_accept & ~req_we;

   assign ram_rst  = ~rst_n;
   assign ram_en   = w_accept;
   assign ram_we   = w_accept & req_we;
   assign ram_addr = req_addr;
   assign ram_din  = req_wdata;

   // The oldest stage of the tracker marks the cycle in which ram_dout holds
   // the data for a read issued LATENCY cycles earlier.
   assign w_push    = r_inflight[LATENCY-1];
   assign rsp_valid = (r_count != '0);
   assign rsp_data  = r_mem[r_rdPtr];
   assign w_pop     = rsp_valid & rsp_ready;

   // Valid bits for reads travelling through the RAM pipeline. Clearing them
   // on reset discards any read still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= '0;
      end else begin
         r_inflight[0] <= w_rdAccept;
         for (int i = 1; i < LATENCY; i++) begin
            r_inflight[i] <= r_inflight[i-1];
         end
      end
   end

   // FIFO storage needs no reset; occupancy is defined by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= ram_dout;
      end
   end

   // FIFO pointers and occupancy. A simultaneous push and pop leaves the
   // count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= nextPtr(r_wrPtr);
         end
         if (w_pop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Outstanding reads = reads in the RAM pipeline + FIFO entries. A push
   // only moves a read from one part of that sum to the other, so the total
   // changes only on read acceptance and on response pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outstanding <= '0;
      end else begin
         case ({w_rdAccept, w_pop})
            2'b10:   r_outstanding <= r_outstanding + CW'(1);
            2'b01:   r_outstanding <= r_outstanding - CW'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // The credit scheme makes a push into a full FIFO impossible.
   fifoNoOverflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_spram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spram_access_ctrl
//   Drives spram_access_ctrl (LATENCY=1, FIFO_DEPTH=3) connected to a
//   behavioural RAM, with directed scenarios followed by random traffic.
//   The reference keeps a plain word array and a queue of expected responses,
//   each tagged with the first cycle it may appear; credits are simply reads
//   accepted minus responses taken. A second instance with LATENCY=2 checks
//   the longer read-to-response latency.
// ---------------------------------------------------------------------------
module tb_spram_access_ctrl;

   localparam int DW    = 32;
   localparam int DEPTH = 128;
   localparam int AW    = 7;
   localparam int LAT   = 1;
   localparam int FD    = 3;
   localparam int LAT2  = 2;
   localparam int FD2   = 4;

   typedef struct {
      logic [DW-1:0] d;
      int            t;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          reqValid, reqReady, reqWe;
   logic [AW-1:0] reqAddr;
   logic [DW-1:0] reqWdata;
   logic          rspValid, rspReady;
   logic [DW-1:0] rspData;
   logic          ramRst, ramEn, ramWe;
   logic [AW-1:0] ramAddr;
   logic [DW-1:0] ramDin, ramDout;

   logic          reqValid2, reqReady2, reqWe2;
   logic [AW-1:0] reqAddr2;
   logic [DW-1:0] reqWdata2;
   logic          rspValid2, rspReady2;
   logic [DW-1:0] rspData2;
   logic          ramRst2, ramEn2, ramWe2;
   logic [AW-1:0] ramAddr2;
   logic [DW-1:0] ramDin2, ramDout2;

   logic [DW-1:0] ramArr  [DEPTH];
   logic [DW-1:0] ramPipe [LAT];
   logic [DW-1:0] ramArr2 [DEPTH];
   logic [DW-1:0] ramPipe2[LAT2];
   logic [DW-1:0] refMem  [DEPTH];

   rsp_t q[$];
   int   credits = 0;
   int   cyc = 0;
   int   nChecks = 0;
   int   nPass = 0;

   spram_access_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT), .FIFO_DEPTH(FD)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
      .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_data(rspData),
      .ram_rst(ramRst), .ram_en(ramEn), .ram_we(ramWe),
      .ram_addr(ramAddr), .ram_din(ramDin), .ram_dout(ramDout)
   );

   spram_access_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT2), .FIFO_DEPTH(FD2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(reqValid2), .req_ready(reqReady2), .req_we(reqWe2),
      .req_addr(reqAddr2), .req_wdata(reqWdata2),
      .rsp_valid(rspValid2), .rsp_ready(rspReady2), .rsp_data(rspData2),
      .ram_rst(ramRst2), .ram_en(ramEn2), .ram_we(ramWe2),
      .ram_addr(ramAddr2), .ram_din(ramDin2), .ram_dout(ramDout2)
   );

   // Behavioural single-port RAMs: synchronous write, read data delayed by
   // the RAM latency through a small pipeline.
   always @(posedge clk) begin
      ramPipe[0] <= (ramEn && !ramWe) ? ramArr[ramAddr] : 'x;
      for (int i = LAT - 1; i > 0; i--) ramPipe[i] <= ramPipe[i-1];
      if (ramEn && ramWe) ramArr[ramAddr] = ramDin;
   end
   assign ramDout = ramPipe[LAT-1];

   always @(posedge clk) begin
      ramPipe2[0] <= (ramEn2 && !ramWe2) ? ramArr2[ramAddr2] : 'x;
      for (int i = LAT2 - 1; i > 0; i--) ramPipe2[i] <= ramPipe2[i-1];
      if (ramEn2 && ramWe2) ramArr2[ramAddr2] = ramDin2;
   end
   assign ramDout2 = ramPipe2[LAT2-1];

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
   endtask

   // One clock cycle on the main instance: drive, then check against the
   // reference and advance it.
   task automatic applyStimulus(input logic rstn, input logic v, input logic we,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic rr);
      logic expReady, expValid, accept;
      rsp_t e;
      @(posedge clk);
      #1;
      rst_n = rstn; reqValid = v; reqWe = we; reqAddr = a; reqWdata = wd; rspReady = rr;
      #3;
      if (!rstn) begin
         q.delete();
         credits = 0;
      end
      expReady = rstn && (we || credits < FD);
      expValid = (q.size() > 0) && (q[0].t <= cyc);
      accept   = v && expReady;
      checkOutput("reqReady", {31'd0, reqReady}, {31'd0, expReady});
      checkOutput("rspValid", {31'd0, rspValid}, {31'd0, expValid});
      if (expValid) checkOutput("rspData", rspData, q[0].d);
      checkOutput("ramRst", {31'd0, ramRst}, {31'd0, !rstn});
      checkOutput("ramEn", {31'd0, ramEn}, {31'd0, accept});
      checkOutput("ramWe", {31'd0, ramWe}, {31'd0, accept && we});
      if (accept) begin
         checkOutput("ramAddr", {25'd0, ramAddr}, {25'd0, a});
         if (we) begin
            checkOutput("ramDin", ramDin, wd);
            refMem[a] = wd;
         end else begin
            e.d = refMem[a];
            e.t = cyc + LAT + 1;
            q.push_back(e);
            credits++;
         end
      end
      if (expValid && rr) begin
         void'(q.pop_front());
         credits--;
      end
      cyc++;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ramArr[i]  = i * 32'h11;
         refMem[i]  = i * 32'h11;
         ramArr2[i] = 32'h0;
      end
      rst_n = 1'b0;
      reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0; rspReady = 1'b0;
      reqValid2 = 1'b0; reqWe2 = 1'b0; reqAddr2 = '0; reqWdata2 = '0; rspReady2 = 1'b1;

      $display("[TB] reset held with a request pending");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 7'd3, 32'h0, 1'b1);

      $display("[TB] LATENCY=2 instance: write then read @5");
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         rst_n = 1'b1; reqValid = 1'b0;
         reqValid2 = (k < 2); reqWe2 = (k == 0); reqAddr2 = 7'd5; reqWdata2 = 32'hDEADBEEF;
         #3;
         if (k < 2) checkOutput("lat2ReqReady", {31'd0, reqReady2}, 32'd1);
         if (k == 2 || k == 3 || k == 5) checkOutput("lat2NoRsp", {31'd0, rspValid2}, 32'd0);
         if (k == 4) begin
            checkOutput("lat2RspValid", {31'd0, rspValid2}, 32'd1);
            checkOutput("lat2RspData", rspData2, 32'hDEADBEEF);
         end
      end
      reqValid2 = 1'b0;

      $display("[TB] back-to-back reads @0..7");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, AW'(i), 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1);

      $display("[TB] write then read-after-write @5");
      applyStimulus(1'b1, 1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 7'd5, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1);

      $display("[TB] response backpressure, write still accepted");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, AW'(i + 1), 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 7'd9, 32'hCAFE0009, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1);

      $display("[TB] reset with reads in flight");
      applyStimulus(1'b1, 1'b1, 1'b0, 7'd2, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 7'd3, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 7'd9, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1);

      $display("[TB] full FIFO, pop and new read in the same cycle");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, AW'(10 + i), 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 7'd13, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 7'd13, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1);

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 199) != 0),
                       ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 9) < 3),
                       AW'($urandom_range(0, 15)),
                       $urandom(),
                       ($urandom_range(0, 9) < 6));
      end
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 1'b1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
